// File: rtl/instruction_register_if.sv
// Bus between memory/control unit and the instruction register.
// The master side supplies the memory word and load enable and consumes the
// decoded field slices. The slave side is the instruction register itself.
interface instruction_register_if;
  logic [15:0] D_MemData;
  logic        C_IRWrite;
  logic [3:0]  OPCODE;
  logic [3:0]  FUNCFIELD;
  logic [3:0]  A_ReadReg1RT;
  logic [3:0]  A_ReadReg2RT;
  logic [1:0]  A_Offset;
  logic [1:0]  A_RegSWLW;
  logic [3:0]  A_WriteRegRT_BT;

  modport master (
    output D_MemData,
    output C_IRWrite,
    input  OPCODE,
    input  FUNCFIELD,
    input  A_ReadReg1RT,
    input  A_ReadReg2RT,
    input  A_Offset,
    input  A_RegSWLW,
    input  A_WriteRegRT_BT
  );

  modport slave (
    input  D_MemData,
    input  C_IRWrite,
    output OPCODE,
    output FUNCFIELD,
    output A_ReadReg1RT,
    output A_ReadReg2RT,
    output A_Offset,
    output A_RegSWLW,
    output A_WriteRegRT_BT
  );
endinterface

// File: rtl/instruction_register.sv
// 16-bit instruction register for the multicycle datapath.
// Loads the memory word when the control unit asserts C_IRWrite and exposes
// fixed bit-field slices of the stored word. No opcode decoding happens here;
// every output is a direct wire from the register, so all outputs are glitch-free.
module instruction_register (
  input logic                  clk,
  input logic                  rst,
  instruction_register_if.slave bus
);

  logic [15:0] ir_q;
  logic [15:0] ir_d;

  // Next-state: take the memory word on a load, otherwise hold.
  always_comb begin
    ir_d = ir_q;
    if (bus.C_IRWrite) begin
      ir_d = bus.D_MemData;
    end
  end

  // State register with synchronous reset taking priority over a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= 16'h0000;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Field slices. Overlaps are intentional: read port 1 and the write/branch
  // register share IR[11:8], and the load/store fields split IR[7:4].
  assign bus.OPCODE          = ir_q[15:12];
  assign bus.A_ReadReg1RT    = ir_q[11:8];
  assign bus.A_WriteRegRT_BT = ir_q[11:8];
  assign bus.A_ReadReg2RT    = ir_q[7:4];
  assign bus.A_RegSWLW       = ir_q[7:6];
  assign bus.A_Offset        = ir_q[5:4];
  assign bus.FUNCFIELD       = ir_q[3:0];

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register: the stimulus process updates a
// word-level model and queues the expected field set; the monitor compares
// the DUT outputs against the queue once per cycle.
module tb_instruction_register;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] func;
    logic [3:0] rr1;
    logic [3:0] rr2;
    logic [1:0] off;
    logic [1:0] swlw;
    logic [3:0] wr;
  } fields_t;

  logic clk;
  logic rst;

  instruction_register_if bus_if ();

  instruction_register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fields_t     exp_q[$];
  int unsigned model_word;
  int          checks;
  int          passes;

  // Reference field extraction from an instruction word by plain arithmetic.
  function automatic fields_t fields_of(input int unsigned w);
    fields_t f;
    f.op   = 4'((w / 4096) % 16);
    f.rr1  = 4'((w / 256) % 16);
    f.wr   = 4'((w / 256) % 16);
    f.rr2  = 4'((w / 16) % 16);
    f.swlw = 2'((w / 64) % 4);
    f.off  = 2'((w / 16) % 4);
    f.func = 4'(w % 16);
    return f;
  endfunction

  // Drive one cycle of inputs just after a falling edge and queue the state
  // expected after the following rising edge.
  task automatic step(input logic r, input logic we, input logic [15:0] d);
    @(negedge clk);
    #1;
    rst              = r;
    bus_if.C_IRWrite = we;
    bus_if.D_MemData = d;
    if (r) model_word = 0;
    else if (we) model_word = int'(d);
    exp_q.push_back(fields_of(model_word));
  endtask

  // Monitor: each falling edge, compare outputs with the oldest queued entry.
  initial begin
    fields_t act;
    fields_t exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act.op   = bus_if.OPCODE;
        act.func = bus_if.FUNCFIELD;
        act.rr1  = bus_if.A_ReadReg1RT;
        act.rr2  = bus_if.A_ReadReg2RT;
        act.off  = bus_if.A_Offset;
        act.swlw = bus_if.A_RegSWLW;
        act.wr   = bus_if.A_WriteRegRT_BT;
        checks++;
        if (act !== exp) begin
          $display("FAIL fields @%0t: got op=%h rr1=%h wr=%h rr2=%h func=%h swlw=%b off=%b, want op=%h rr1=%h wr=%h rr2=%h func=%h swlw=%b off=%b",
                   $time, act.op, act.rr1, act.wr, act.rr2, act.func, act.swlw, act.off,
                   exp.op, exp.rr1, exp.wr, exp.rr2, exp.func, exp.swlw, exp.off);
        end else begin
          passes++;
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    logic [15:0] sweep [5];
    checks     = 0;
    passes     = 0;
    model_word = 0;
    rst              = 1'b1;
    bus_if.C_IRWrite = 1'b1;
    bus_if.D_MemData = 16'hFFFF;
    sweep[0] = 16'h0B41;
    sweep[1] = 16'h0B42;
    sweep[2] = 16'h0B43;
    sweep[3] = 16'h9BC9;
    sweep[4] = 16'h3B78;

    // Reset with a pending load: reset wins.
    step(1'b1, 1'b1, 16'hFFFF);
    // Load add, then hold twice with different data on the bus.
    step(1'b0, 1'b1, 16'h8B48);
    step(1'b0, 1'b0, 16'h2BC9);
    step(1'b0, 1'b0, 16'h2BC9);
    // Synchronous reset: the cycle before the edge still shows 8B48.
    step(1'b1, 1'b1, 16'h2BC9);
    // Held reset keeps IR clear despite a load request.
    step(1'b1, 1'b1, 16'h1234);
    // Load sw.
    step(1'b0, 1'b1, 16'h2BC9);
    // Back-to-back opcode sweep.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, sweep[i]);
    // Unknown memory data while not loading must not reach the outputs.
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic we;
      logic [15:0] d;
      r  = ($urandom_range(0, 15) == 0);
      we = $urandom_range(0, 1) == 1;
      d  = 16'($urandom);
      if (!we && !r && $urandom_range(0, 7) == 0) d = 16'hxxxx;
      step(r, we, d);
    end
    step(1'b0, 1'b0, 16'h0000);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- 16-bit instruction register (IR) for the multicycle 16-bit processor datapath.
- Captures the instruction word from memory data when the control unit asserts the IR write enable.
- Presents fixed bit-field slices of the stored word to the control unit (opcode, function field) and to the register file (read/write register addresses, load/store fields).
- Sits between the memory data bus and the controller/register file.

Parameters:
None (widths fixed: 16-bit instruction, 4-bit opcode and register addresses).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
D_MemData  input  16  instruction word from memory
C_IRWrite  input  1  IR load enable from control unit
OPCODE  output  4  IR[15:12]
FUNCFIELD  output  4  IR[3:0], function code for R-type and shift instructions
A_ReadReg1RT  output  4  IR[11:8], register file read port 1 address
A_ReadReg2RT  output  4  IR[7:4], register file read port 2 address
A_Offset  output  2  IR[5:4], load/store offset field
A_RegSWLW  output  2  IR[7:6], load/store base-register select
A_WriteRegRT_BT  output  4  IR[11:8], register file write address / branch target reg

Behaviour:
- One 16-bit internal register IR. All outputs are pure combinational slices of IR, so every output is registered with no logic between IR and the outputs.
- Rising edge of clk, in priority order:
  - rst=1: IR <= 16'h0000, regardless of C_IRWrite.
  - else C_IRWrite=1: IR <= D_MemData.
  - else: IR holds its value.
- Reset values: IR=0, so every output is 0.
- Latency: data loaded at edge N is visible on all outputs immediately after edge N. D_MemData changes while C_IRWrite=0 have no effect.
- Fields are extracted identically for every opcode; there is no decoding inside the block. Examples:
  - R-type (add 1000, sub 1100, lnandr 1011, lorr 1111, be 0100, bne 0101) uses IR[11:8], IR[7:4] and IR[3:0].
  - Shifts (opcode 0000) use func 0001=shl, 0010=shr, 0011=sar.
  - Immediate forms use IR[7:0] as the immediate; the datapath reads it from the outputs, and the block adds no extra port for it.
- Overlapping fields are intentional:
  - A_ReadReg1RT and A_WriteRegRT_BT are always equal.
  - A_RegSWLW and A_Offset together equal A_ReadReg2RT.
- No X propagation on outputs after the first reset, even if D_MemData is X while C_IRWrite=0.
- Reset asserted mid-operation clears IR at the next edge. Holding rst=1 keeps IR=0 even with C_IRWrite=1.

Test Plan:
- Reset: rst=1 for 1 edge with D_MemData=16'hFFFF, C_IRWrite=1 -> all outputs 0.
- Load add: rst=0, C_IRWrite=1, D_MemData=16'h8B48 -> after edge: OPCODE=8, A_ReadReg1RT=B, A_WriteRegRT_BT=B, A_ReadReg2RT=4, FUNCFIELD=8, A_RegSWLW=2'b01, A_Offset=2'b00.
- Hold: C_IRWrite=0, D_MemData=16'h2BC9 for 2 edges -> outputs unchanged from 8B48 decode.
- Synchronous reset priority: rst=1 with C_IRWrite=1. Before the edge, outputs still show 8B48 (reset is not asynchronous). After the edge, all outputs are 0.
- Load sw: rst=0, C_IRWrite=1, D_MemData=16'h2BC9 -> OPCODE=2, A_ReadReg1RT=B, A_ReadReg2RT=C, FUNCFIELD=9, A_RegSWLW=2'b11, A_Offset=2'b00.
- Opcode sweep: load 16'h0B41, 0B42, 0B43, 9BC9, 3B78 back-to-back with C_IRWrite=1. Each edge updates the fields, e.g. 3B78 -> OPCODE=3, A_ReadReg1RT=B, A_ReadReg2RT=7, FUNCFIELD=8.
